mem_stage: RTL and testbench

- Memory-access stage directly downstream of the EX/MEM pipeline register in the multicycle processor.
- Consumes the registered ALU result, store data, destination register, PC and memory-control bits.
- Runs a req/ack transaction with data memory, stalling the upstream pipeline until it completes.
- Contains the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_stage_if.sv | 20 ++
 rtl/mem_stage.sv | 176 +++++++++++++++++
 tb/tb_mem_stage.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and data memory (slave).
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: req/ack transaction with data memory, upstream stall,
// byte/word formatting, fault flags and the MEM/WB pipeline register.
//
// state | meaning
// IDLE  | no access in flight; non-memory and misaligned ops pass straight to WB
// BUSY  | mem_req held high, waiting for mem_ack or timeout
// DONE  | access finished; MEM/WB loads this edge, upstream released
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] aluout,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  writereg,
    input  logic [31:0] pcEM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic        ByteM,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    mem_stage_if.master mem,
    output logic        stall_mem,
    output logic [31:0] ReadDataW,
    output logic [31:0] aluoutW,
    output logic [4:0]  writeregW,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] pcMW,
    output logic        align_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        acc, mis, start, timeout, wb_load;
    logic [7:0]  cnt;
    logic [31:0] rdata_q;
    logic        fault_q;
    logic [7:0]  byte_sel;
    logic [31:0] load_val;

    assign acc     = MemReadM | MemWriteM;
    assign mis     = acc & ~ByteM & (aluout[1:0] != 2'b00);
    assign start   = acc & ~mis;
    // Ack wins over a simultaneous timeout.
    assign timeout = (state == BUSY) & ~mem.mem_ack & (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (mem.mem_ack || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stall and MEM/WB load enable; stall is forced low while reset is asserted
    always_comb begin
        stall_mem = 1'b0;
        wb_load   = 1'b0;
        case (state)
            IDLE: begin
                stall_mem = start;
                wb_load   = ~start;
            end
            BUSY:    stall_mem = 1'b1;
            DONE:    wb_load   = 1'b1;
            default: wb_load   = 1'b0;
        endcase
        if (!rst_n) stall_mem = 1'b0;
    end

    // BUSY-cycle counter for the ack timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (state == BUSY && !mem.mem_ack && !timeout) begin
            cnt <= cnt + 8'd1;
        end else begin
            cnt <= 8'd0;
        end
    end

    // Bus request and transaction fields, latched on BUSY entry and held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'd0;
            mem.mem_wdata <= 32'd0;
            mem.mem_be    <= 4'd0;
        end else begin
            mem.mem_req <= (state_nxt == BUSY);
            if (state == IDLE && start) begin
                mem.mem_we    <= MemWriteM;
                mem.mem_addr  <= {aluout[31:2], 2'b00};
                mem.mem_be    <= ByteM ? (4'b0001 << aluout[1:0]) : 4'b1111;
                mem.mem_wdata <= ByteM ? {4{WriteDataM[7:0]}} : WriteDataM;
            end
        end
    end

    // Read-data capture on ack; fault marker on timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else if (state == BUSY) begin
            if (mem.mem_ack) begin
                rdata_q <= mem.mem_rdata;
                fault_q <= 1'b0;
            end else if (timeout) begin
                fault_q <= 1'b1;
            end
        end
    end

    // Byte lane select for byte loads (EX/MEM is frozen, so aluout still names the lane)
    always_comb begin
        case (aluout[1:0])
            2'd0:    byte_sel = rdata_q[7:0];
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        load_val = ByteM ? {{24{byte_sel[7]}}, byte_sel} : rdata_q;
    end

    // MEM/WB pipeline register; holds while the stage stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ReadDataW <= 32'd0;
            aluoutW   <= 32'd0;
            writeregW <= 5'd0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            pcMW      <= 32'd0;
        end else if (wb_load) begin
            aluoutW   <= aluout;
            writeregW <= writereg;
            MemtoRegW <= MemtoRegM;
            pcMW      <= pcEM;
            if (state == DONE) begin
                RegWriteW <= RegWriteM & ~fault_q;
                ReadDataW <= (MemReadM && !fault_q) ? load_val : 32'd0;
            end else begin
                RegWriteW <= RegWriteM & ~mis;
                ReadDataW <= 32'd0;
            end
        end
    end

    // Sticky fault flags, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_err <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            if (state == IDLE && mis) align_err <= 1'b1;
            if (timeout)              bus_err   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, reset sequences and random traffic.
module tb_mem_stage;
    localparam int TIMEOUT = 16;

    logic        clk, rst_n;
    logic [31:0] aluout, WriteDataM, pcEM;
    logic [4:0]  writereg;
    logic        MemReadM, MemWriteM, ByteM, RegWriteM, MemtoRegM;
    logic        stall_mem;
    logic [31:0] ReadDataW, aluoutW, pcMW;
    logic [4:0]  writeregW;
    logic        RegWriteW, MemtoRegW, align_err, bus_err;

    mem_stage_if mif();

    mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .aluout(aluout), .WriteDataM(WriteDataM), .writereg(writereg), .pcEM(pcEM),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ByteM(ByteM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .mem(mif.master),
        .stall_mem(stall_mem), .ReadDataW(ReadDataW), .aluoutW(aluoutW),
        .writeregW(writeregW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .pcMW(pcMW), .align_err(align_err), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu, wd, pc, rdata;
        logic [4:0]  wreg;
        logic        rd, wr, byt, regw, m2r;
        int          k;          // ack on the k-th BUSY cycle; 0 = never ack
        int          exp_stall;
        logic [31:0] exp_rdw;
        logic        exp_regw;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cur_tag = 0;
    logic seen_align = 1'b0;
    logic seen_bus   = 1'b0;
    vec_t tab [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL [%0d] %s: got 0x%08h, expected 0x%08h", cur_tag, name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] alu, wd, pc, rdata, input logic [4:0] wreg,
                                input logic rd, wr, byt, regw, m2r, input int k, es,
                                input logic [31:0] erd, input logic erw);
        vec_t v;
        v.alu = alu; v.wd = wd; v.pc = pc; v.rdata = rdata; v.wreg = wreg;
        v.rd = rd; v.wr = wr; v.byt = byt; v.regw = regw; v.m2r = m2r;
        v.k = k; v.exp_stall = es; v.exp_rdw = erd; v.exp_regw = erw;
        return v;
    endfunction

    // Reference load formatting: pick byte lane, sign-extend, or pass the whole word.
    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] off, input logic byt);
        logic [31:0] b;
        if (!byt) return rd;
        b = (rd >> (8 * off)) & 32'h0000_00FF;
        if (b >= 32'h80) b = b | 32'hFFFF_FF00;
        return b;
    endfunction

    task automatic drive(input vec_t v);
        aluout = v.alu; WriteDataM = v.wd; pcEM = v.pc; writereg = v.wreg;
        MemReadM = v.rd; MemWriteM = v.wr; ByteM = v.byt;
        RegWriteM = v.regw; MemtoRegM = v.m2r;
    endtask

    task automatic apply(input vec_t v, input bit directed, input bit stray_ack);
        logic        acc, mis, tmo, m_regw, bus_ok, bound_hit;
        int          m_stall, m_req, n_stall, n_req;
        logic [31:0] m_rdw, e_addr, e_wdata;
        logic [3:0]  e_be;

        acc = v.rd | v.wr;
        mis = acc & ~v.byt & (v.alu[1:0] != 2'b00);
        tmo = acc & ~mis & (v.k == 0);
        if (!acc || mis) begin
            m_stall = 0; m_req = 0;
        end else if (tmo) begin
            m_stall = TIMEOUT + 1; m_req = TIMEOUT;
        end else begin
            m_stall = 1 + v.k; m_req = v.k;
        end
        m_regw = v.regw & ~mis & ~tmo;
        m_rdw  = (acc && !mis && !tmo && v.rd) ? ref_load(v.rdata, v.alu[1:0], v.byt) : 32'd0;
        if (mis) seen_align = 1'b1;
        if (tmo) seen_bus   = 1'b1;
        e_addr  = v.alu & ~32'h3;
        e_be    = v.byt ? 4'(1 << v.alu[1:0]) : 4'hF;
        e_wdata = v.byt ? {4{v.wd[7:0]}} : v.wd;

        @(negedge clk);
        drive(v);
        mif.mem_ack   = stray_ack;
        mif.mem_rdata = $urandom;
        n_stall = 0; n_req = 0; bus_ok = 1'b1; bound_hit = 1'b1;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (!stall_mem) begin
                bound_hit = 1'b0;
                break;
            end
            n_stall++;
            @(negedge clk);
            mif.mem_ack   = 1'b0;
            mif.mem_rdata = $urandom;
            if (mif.mem_req) begin
                n_req++;
                if (mif.mem_we !== v.wr || mif.mem_addr !== e_addr ||
                    mif.mem_be !== e_be || mif.mem_wdata !== e_wdata) bus_ok = 1'b0;
                if (v.k > 0 && n_req == v.k) begin
                    mif.mem_ack   = 1'b1;
                    mif.mem_rdata = v.rdata;
                end
            end
        end
        chk("stall_bound", {31'd0, bound_hit}, 32'd0);
        @(posedge clk);
        #1;
        mif.mem_ack = 1'b0;
        chk("stall_cycles", n_stall, m_stall);
        chk("req_cycles", n_req, m_req);
        chk("bus_fields", {31'd0, bus_ok}, 32'd1);
        chk("req_after", {31'd0, mif.mem_req}, 32'd0);
        chk("aluoutW", aluoutW, v.alu);
        chk("writeregW", {27'd0, writeregW}, {27'd0, v.wreg});
        chk("pcMW", pcMW, v.pc);
        chk("MemtoRegW", {31'd0, MemtoRegW}, {31'd0, v.m2r});
        chk("RegWriteW", {31'd0, RegWriteW}, {31'd0, m_regw});
        chk("ReadDataW", ReadDataW, m_rdw);
        chk("align_err", {31'd0, align_err}, {31'd0, seen_align});
        chk("bus_err", {31'd0, bus_err}, {31'd0, seen_bus});
        if (directed) begin
            chk("tab_stall", n_stall, v.exp_stall);
            chk("tab_ReadDataW", ReadDataW, v.exp_rdw);
            chk("tab_RegWriteW", {31'd0, RegWriteW}, {31'd0, v.exp_regw});
        end
        cur_tag++;
    endtask

    initial begin
        //            alu           wd            pc            rdata         wreg  rd wr by rw mr k  stall exp_rdw       exp_rw
        tab[0] = mk(32'h0000_0010, 32'h0,        32'h1000,     32'h0,        5'd5,  0, 0, 0, 1, 0, 0, 0,  32'h0,        1);
        tab[1] = mk(32'h0000_0100, 32'h0,        32'h1004,     32'hDEAD_BEEF, 5'd7, 1, 0, 0, 1, 1, 1, 2,  32'hDEAD_BEEF, 1);
        tab[2] = mk(32'h0000_0103, 32'h0,        32'h1008,     32'h8011_2233, 5'd8, 1, 0, 1, 1, 1, 3, 4,  32'hFFFF_FF80, 1);
        tab[3] = mk(32'h0000_0201, 32'h0000_00AB, 32'h100C,    32'h0,        5'd0,  0, 1, 1, 0, 0, 1, 2,  32'h0,        0);
        tab[4] = mk(32'h0000_0102, 32'h0,        32'h1010,     32'h5555_5555, 5'd9, 1, 0, 0, 1, 1, 1, 0,  32'h0,        0);
        tab[5] = mk(32'h0000_0300, 32'h1234_5678, 32'h1014,    32'h0,        5'd0,  0, 1, 0, 0, 0, 2, 3,  32'h0,        0);
        tab[6] = mk(32'h0000_0101, 32'h0,        32'h1018,     32'h1122_7F44, 5'd10, 1, 0, 1, 1, 1, 1, 2, 32'h0000_007F, 1);
        tab[7] = mk(32'h0000_0400, 32'h0,        32'h101C,     32'h0000_0099, 5'd11, 1, 0, 0, 1, 1, 0, 17, 32'h0,       0);
        tab[8] = mk(32'h0000_CAFE, 32'h0,        32'h1020,     32'h0,        5'd12, 0, 0, 0, 1, 0, 0, 0,  32'h0,        1);

        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'd0;
        #3;
        chk("rst_mem_req", {31'd0, mif.mem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall_mem}, 32'd0);
        chk("rst_ReadDataW", ReadDataW, 32'd0);
        chk("rst_aluoutW", aluoutW, 32'd0);
        chk("rst_RegWriteW", {31'd0, RegWriteW}, 32'd0);
        chk("rst_flags", {30'd0, align_err, bus_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) apply(tab[i], 1'b1, 1'b0);

        // Reset in the middle of a BUSY access, then a late ack that must be ignored.
        @(negedge clk);
        drive(mk(32'h500, 0, 32'h2000, 0, 5'd3, 1, 0, 0, 1, 1, 0, 0, 0, 0));
        mif.mem_ack = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_req", {31'd0, mif.mem_req}, 32'd1);
        chk("busy_stall", {31'd0, stall_mem}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'd0, mif.mem_req}, 32'd0);
        chk("midrst_stall", {31'd0, stall_mem}, 32'd0);
        chk("midrst_flags", {30'd0, align_err, bus_err}, 32'd0);
        chk("midrst_pcMW", pcMW, 32'd0);
        seen_align = 1'b0;
        seen_bus   = 1'b0;
        drive(mk(32'h77, 0, 32'h2004, 0, 5'd4, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mif.mem_ack = 1'b0;
        chk("late_ack_stall", {31'd0, stall_mem}, 32'd0);
        chk("late_ack_req", {31'd0, mif.mem_req}, 32'd0);
        chk("late_ack_aluoutW", aluoutW, 32'h77);
        chk("late_ack_ReadDataW", ReadDataW, 32'd0);
        chk("late_ack_RegWriteW", {31'd0, RegWriteW}, 32'd1);

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            int   ty;
            ty = $urandom_range(0, 2);
            v.alu = $urandom; v.wd = $urandom; v.pc = $urandom; v.rdata = $urandom;
            if ($urandom_range(0, 1) == 1) v.alu[1:0] = 2'b00;
            v.wreg = 5'($urandom); v.byt = 1'($urandom);
            v.regw = 1'($urandom); v.m2r = 1'($urandom);
            v.rd = (ty == 1); v.wr = (ty == 2);
            v.k = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
            v.exp_stall = 0; v.exp_rdw = 32'd0; v.exp_regw = 1'b0;
            apply(v, 1'b0, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
